nios_ocimem_arbiter: RTL

- Arbitrates the Nios II on-chip debug RAM (OCI memory) between two requesters: the JTAG debug path and the CPU's Avalon-MM debug-memory slave port.
- The JTAG path is driven by the take_action_ocimem_* strobes, already synchronised into clk.
- Sits between the debug-slave sysclk logic and a single-port RAM with 1-cycle read latency. It sequences address load, read and write with auto-increment, and returns read data in MonDReg style.

---
 rtl/nios_ocimem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/nios_ocimem_arbiter.sv
// Shares the Nios II OCI debug RAM between the JTAG debug path and the CPU's
// Avalon-MM debug slave. Handles the JTAG pointer and overrun, round-robin grants and read sequencing.
module nios_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  jtag_load_addr,
  input  logic                  jtag_wr,
  input  logic                  jtag_rd,
  input  logic [ADDR_W-1:0]     jtag_addr,
  input  logic [DATA_W-1:0]     jtag_wdata,
  output logic [DATA_W-1:0]     mon_dreg,
  output logic                  mon_busy,
  output logic                  jtag_overrun,
  input  logic [ADDR_W-1:0]     av_address,
  input  logic                  av_read,
  input  logic                  av_write,
  input  logic [DATA_W-1:0]     av_writedata,
  input  logic [DATA_W/8-1:0]   av_byteenable,
  output logic [DATA_W-1:0]     av_readdata,
  output logic                  av_waitrequest,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wren,
  output logic [DATA_W/8-1:0]   ram_byteen,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  typedef enum logic [1:0] {IDLE, JTAG_RD, AV_RD} state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   pointer;
  logic [ADDR_W-1:0]   addr_q;
  logic                pend_wr;
  logic [DATA_W-1:0]   pend_wdata;
  logic [DATA_W-1:0]   av_rdata_q;
  logic                last_grant_av;
  logic                jtag_req;
  logic                av_req;
  logic                grant_jtag;
  logic                grant_av;
  logic                av_done;
  logic                jtag_done;
  logic                jtag_op;
  logic                jtag_accept;
  logic                jtag_drop;

  // mon_busy doubles as the pending/in-flight flag, so an op is only taken when the slot is empty.
  assign jtag_op     = jtag_wr | jtag_rd;
  assign jtag_accept = jtag_op & ~mon_busy;
  assign jtag_drop   = jtag_op & (mon_busy | (jtag_wr & jtag_rd));

  assign jtag_req   = (state == IDLE) & mon_busy;
  assign av_req     = (state == IDLE) & (av_read | av_write);
  assign grant_jtag = jtag_req & (~av_req | last_grant_av);
  assign grant_av   = av_req & ~grant_jtag;
  assign jtag_done  = (grant_jtag & pend_wr) | (state == JTAG_RD);

  always_comb begin
    state_next = state;
    ram_addr   = addr_q;
    ram_wren   = 1'b0;
    ram_byteen = '0;
    ram_wdata  = '0;
    av_done    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_jtag) begin
          ram_addr = pointer;
          if (pend_wr) begin
            ram_wren   = 1'b1;
            ram_byteen = '1;
            ram_wdata  = pend_wdata;
          end else begin
            state_next = JTAG_RD;
          end
        end else if (grant_av) begin
          ram_addr = av_address;
          // A simultaneous read and write from the CPU is resolved as a write.
          if (av_write) begin
            ram_wren   = 1'b1;
            ram_byteen = av_byteenable;
            ram_wdata  = av_writedata;
            av_done    = 1'b1;
          end else begin
            state_next = AV_RD;
          end
        end
      end
      JTAG_RD: state_next = IDLE;
      AV_RD: begin
        state_next = IDLE;
        av_done    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign av_waitrequest = reset | ((av_read | av_write) & ~av_done);
  assign av_readdata    = (state == AV_RD) ? ram_rdata : av_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr_q        <= '0;
      av_rdata_q    <= '0;
      last_grant_av <= 1'b1;
    end else begin
      state  <= state_next;
      addr_q <= ram_addr;
      if (state == AV_RD) begin
        av_rdata_q <= ram_rdata;
      end
      if (grant_jtag) begin
        last_grant_av <= 1'b0;
      end else if (grant_av) begin
        last_grant_av <= 1'b1;
      end
    end
  end

  // A load on the same cycle as a completing op wins, so the pointer always reflects the latest load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pointer      <= '0;
      mon_dreg     <= '0;
      mon_busy     <= 1'b0;
      jtag_overrun <= 1'b0;
      pend_wr      <= 1'b0;
      pend_wdata   <= '0;
    end else begin
      if (jtag_load_addr) begin
        pointer <= jtag_addr;
      end else if (jtag_done) begin
        pointer <= pointer + ADDR_W'(1);
      end
      if (state == JTAG_RD) begin
        mon_dreg <= ram_rdata;
      end
      if (jtag_done) begin
        mon_busy <= 1'b0;
      end else if (jtag_accept) begin
        mon_busy <= 1'b1;
      end
      if (jtag_accept) begin
        pend_wr    <= jtag_wr;
        pend_wdata <= jtag_wdata;
      end
      if (jtag_drop) begin
        jtag_overrun <= 1'b1;
      end else if (jtag_load_addr) begin
        jtag_overrun <= 1'b0;
      end
    end
  end

endmodule
